// File: rtl/sw_pkg.sv
// Shared types and defaults for the Smith-Waterman array controller:
// base encodings, controller states and default field widths.
package sw_pkg;

    localparam int unsigned SW_SCORE_WIDTH = 10;
    localparam int unsigned SW_LEN_WIDTH   = 16;

    typedef enum logic [1:0] {
        BASE_A = 2'b00,
        BASE_C = 2'b01,
        BASE_G = 2'b10,
        BASE_T = 2'b11
    } sw_base_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } sw_state_e;

endpackage

// File: rtl/sw_max_tracker.sv
// Capture counter and running best score/position of the last PE's V output.
// Position tracking is built only when SW_ARRAY_CTRL_POS_EN is defined.
module sw_max_tracker
    import sw_pkg::*;
#(
    parameter int unsigned SCORE_WIDTH = SW_SCORE_WIDTH,
    parameter int unsigned LEN_WIDTH   = SW_LEN_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_clear,
    input  logic                   i_capture,
    input  logic [SCORE_WIDTH-1:0] i_v,
    output logic [LEN_WIDTH-1:0]   o_cap_cnt,
    output logic [SCORE_WIDTH-1:0] o_best_score,
    output logic [LEN_WIDTH-1:0]   o_best_pos
);

    logic [LEN_WIDTH-1:0]   r_cap_cnt;
    logic [SCORE_WIDTH-1:0] r_best_score;
    logic                   w_better;

    // Signed compare; best starts at 0 so it can never go negative.
    assign w_better = $signed(i_v) > $signed(r_best_score);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_cnt    <= '0;
            r_best_score <= '0;
        end else if (i_clear) begin
            r_cap_cnt    <= '0;
            r_best_score <= '0;
        end else if (i_capture) begin
            r_cap_cnt <= r_cap_cnt + LEN_WIDTH'(1);
            if (w_better) begin
                r_best_score <= i_v;
            end
        end
    end

`ifdef SW_ARRAY_CTRL_POS_EN
    logic [LEN_WIDTH-1:0] r_best_pos;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_best_pos <= '0;
        end else if (i_clear) begin
            r_best_pos <= '0;
        end else if (i_capture && w_better) begin
            r_best_pos <= r_cap_cnt;
        end
    end

    assign o_best_pos = r_best_pos;
`else
    assign o_best_pos = '0;
`endif

    assign o_cap_cnt    = r_cap_cnt;
    assign o_best_score = r_best_score;

endmodule

// File: rtl/sw_array_ctrl.sv
// Sequencer for a linear Smith-Waterman systolic array: shifts in the read, streams the
// reference with stalls, and reports the best score (best_pos only with SW_ARRAY_CTRL_POS_EN).
module sw_array_ctrl
    import sw_pkg::*;
#(
    parameter int unsigned NUM_PE      = 64,
    parameter int unsigned SCORE_WIDTH = SW_SCORE_WIDTH,
    parameter int unsigned LEN_WIDTH   = SW_LEN_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [LEN_WIDTH-1:0]   ref_len,
    input  logic [1:0]             read_base,
    input  logic                   read_valid,
    output logic                   read_ready,
    input  logic [1:0]             ref_base,
    input  logic                   ref_valid,
    output logic                   ref_ready,
    output logic [1:0]             arr_S,
    output logic                   arr_store_S,
    output logic [1:0]             arr_T,
    output logic                   arr_init,
    output logic                   arr_stall,
    output logic [SCORE_WIDTH-1:0] arr_V,
    output logic [SCORE_WIDTH-1:0] arr_F,
    input  logic [SCORE_WIDTH-1:0] arr_V_last,
    input  logic                   arr_init_last,
    output logic                   busy,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [SCORE_WIDTH-1:0] best_score,
    output logic [LEN_WIDTH-1:0]   best_pos
);

    localparam int unsigned LOAD_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    sw_state_e            r_state;
    logic [LOAD_W-1:0]    r_load_cnt;
    logic [LEN_WIDTH-1:0] r_sent;
    logic [LEN_WIDTH-1:0] r_ref_len;
    logic                 r_read_ready;
    logic                 r_ref_ready;
    logic [1:0]           r_arr_S;
    logic                 r_arr_store_S;
    logic [1:0]           r_arr_T;
    logic                 r_arr_init;
    logic                 r_arr_stall;
    logic                 r_busy;
    logic                 r_result_valid;

    logic                 w_clear;
    logic                 w_capture;
    logic [LEN_WIDTH-1:0] w_cap_cnt;

    // A capture is only real when the array was not frozen in that cycle.
    assign w_clear   = (r_state == ST_IDLE) && start;
    assign w_capture = ((r_state == ST_STREAM) || (r_state == ST_DRAIN))
                       && arr_init_last && !r_arr_stall;

    sw_max_tracker #(
        .SCORE_WIDTH (SCORE_WIDTH),
        .LEN_WIDTH   (LEN_WIDTH)
    ) u_tracker (
        .clk          (clk),
        .rst_n        (rst),
        .i_clear      (w_clear),
        .i_capture    (w_capture),
        .i_v          (arr_V_last),
        .o_cap_cnt    (w_cap_cnt),
        .o_best_score (best_score),
        .o_best_pos   (best_pos)
    );

    // Job sequencer with registered handshakes and array drive.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_IDLE;
            r_load_cnt     <= '0;
            r_sent         <= '0;
            r_ref_len      <= '0;
            r_read_ready   <= 1'b0;
            r_ref_ready    <= 1'b0;
            r_arr_S        <= 2'b00;
            r_arr_store_S  <= 1'b0;
            r_arr_T        <= 2'b00;
            r_arr_init     <= 1'b0;
            r_arr_stall    <= 1'b0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            r_arr_store_S <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_ref_len    <= ref_len;
                        r_load_cnt   <= '0;
                        r_sent       <= '0;
                        r_read_ready <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (read_valid && r_read_ready) begin
                        r_arr_S       <= read_base;
                        r_arr_store_S <= 1'b1;
                        if (r_load_cnt == LOAD_W'(NUM_PE - 1)) begin
                            r_read_ready <= 1'b0;
                            if (r_ref_len == '0) begin
                                r_result_valid <= 1'b1;
                                r_state        <= ST_DONE;
                            end else begin
                                r_ref_ready <= 1'b1;
                                r_state     <= ST_STREAM;
                            end
                        end else begin
                            r_load_cnt <= r_load_cnt + LOAD_W'(1);
                        end
                    end
                end
                ST_STREAM: begin
                    // No transfer freezes the array; T and init keep their last values.
                    if (ref_valid && r_ref_ready) begin
                        r_arr_T     <= ref_base;
                        r_arr_init  <= 1'b1;
                        r_arr_stall <= 1'b0;
                        r_sent      <= r_sent + LEN_WIDTH'(1);
                        if (r_sent == r_ref_len - LEN_WIDTH'(1)) begin
                            r_ref_ready <= 1'b0;
                            r_state     <= ST_DRAIN;
                        end
                    end else begin
                        r_arr_stall <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    r_arr_stall <= 1'b0;
                    r_arr_init  <= 1'b0;
                    r_arr_T     <= BASE_A;
                    if (w_cap_cnt == r_ref_len) begin
                        r_result_valid <= 1'b1;
                        r_state        <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (result_ready) begin
                        r_result_valid <= 1'b0;
                        r_busy         <= 1'b0;
                        r_state        <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign read_ready   = r_read_ready;
    assign ref_ready    = r_ref_ready;
    assign arr_S        = r_arr_S;
    assign arr_store_S  = r_arr_store_S;
    assign arr_T        = r_arr_T;
    assign arr_init     = r_arr_init;
    assign arr_stall    = r_arr_stall;
    assign arr_V        = '0;
    assign arr_F        = '0;
    assign busy         = r_busy;
    assign result_valid = r_result_valid;

endmodule
